ps2_key_decoder: RTL

- Consumes the byte stream from PS2_Controller (KEY_VALUE/KEY_VALID, scan code set 2) and turns make/break sequences into single-cycle game commands for the tic-tac-toe cursor/game FSM.
- Handles E0 extended and F0 break prefixes, recovers from truncated sequences with a timeout, and suppresses typematic repeats of a held key.

---
 rtl/ps2_key_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 make/break byte sequences (E0/F0 prefixes) into one-cycle game commands.
// Latency: CMD/CMD_VALID and SEQ_ERR are registered, one cycle after the final KEY_VALID.
// No backpressure: one byte per cycle is accepted; define KEY_REPEAT_EN to pass typematic repeats.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 80000,
    parameter int CNT_W          = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] KEY_VALUE,
    input  logic       KEY_VALID,
    output logic [2:0] CMD,
    output logic       CMD_VALID,
    output logic       HELD,
    output logic       SEQ_ERR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       BYTE_EXT = 8'hE0;
    localparam logic [7:0]       BYTE_BRK = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       cmd_q;
    logic [2:0]       held_q;
    logic             cmd_vld_q;
    logic             seq_err_q;

    logic [2:0] key_cmd;
    logic       is_prefix;
    logic       is_make;
    logic       is_break;
    logic       fire;
    logic       expired;

    // Same key map with or without the E0 prefix; 0 means unmapped.
    function automatic logic [2:0] map_code(input logic [7:0] b);
        logic [2:0] c;
        case (b)
            8'h75:   c = 3'd1;
            8'h72:   c = 3'd2;
            8'h6B:   c = 3'd3;
            8'h74:   c = 3'd4;
            8'h5A:   c = 3'd5;
            8'h29:   c = 3'd5;
            8'h76:   c = 3'd6;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    assign key_cmd   = map_code(KEY_VALUE);
    assign is_prefix = (KEY_VALUE == BYTE_EXT) || (KEY_VALUE == BYTE_BRK);
    // Inside a break state any byte, even E0/F0, is the released key code.
    assign is_break  = KEY_VALID && ((state_q == S_BRK) || (state_q == S_EXT_BRK));
    assign is_make   = KEY_VALID && !is_prefix && ((state_q == S_IDLE) || (state_q == S_EXT));
    // A byte arriving on the expiry cycle wins, so expiry requires no strobe.
    assign expired   = !KEY_VALID && (state_q != S_IDLE) && (cnt_q == CNT_LAST);

`ifdef KEY_REPEAT_EN
    assign fire = (key_cmd != 3'd0);
`else
    assign fire = (key_cmd != 3'd0) && (key_cmd != held_q);
`endif

    // Prefix FSM, timeout counter, held-key tracking and registered command outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= 3'd0;
            held_q    <= 3'd0;
            cmd_vld_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            cmd_vld_q <= 1'b0;
            seq_err_q <= 1'b0;

            if (is_make && (key_cmd != 3'd0)) begin
                held_q <= key_cmd;
                if (fire) begin
                    cmd_q     <= key_cmd;
                    cmd_vld_q <= 1'b1;
                end
            end

            if (is_break && (key_cmd != 3'd0) && (key_cmd == held_q)) begin
                held_q <= 3'd0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (KEY_VALID && (KEY_VALUE == BYTE_EXT)) begin
                        state_q <= S_EXT;
                    end else if (KEY_VALID && (KEY_VALUE == BYTE_BRK)) begin
                        state_q <= S_BRK;
                    end
                end
                S_EXT: begin
                    if (KEY_VALID) begin
                        cnt_q <= '0;
                        if (KEY_VALUE == BYTE_BRK) begin
                            state_q <= S_EXT_BRK;
                        end else if (KEY_VALUE != BYTE_EXT) begin
                            state_q <= S_IDLE;
                        end
                    end else if (expired) begin
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                        seq_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    if (KEY_VALID) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (expired) begin
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                        seq_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign CMD       = cmd_q;
    assign CMD_VALID = cmd_vld_q;
    assign HELD      = (held_q != 3'd0);
    assign SEQ_ERR   = seq_err_q;

endmodule
